// File: rtl/bram_sdp_mlx.sv
// bram_sdp_mlx: simple-dual-port RAM with lane-masked writes, 1/2-cycle reads, collision mode and clear sweep
module bram_sdp_mlx #(
    parameter int WIDTH = 12,
    parameter int ADDR_W = 8,
    parameter int LANES = 3,
    parameter int READ_LATENCY = 1,
    parameter int RW_MODE = 0,
    parameter INIT_F = 0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [LANES-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr_write,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr_read,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int LW = WIDTH / LANES;
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_cnt;
    logic r_done, r_v1, r_v2, w_last, w_wr_en, w_rd_en, w_col;
    logic [WIDTH-1:0] r_d1, r_d2, w_bits, w_rd_word;
    if (WIDTH % LANES != 0) begin : g_chk_lanes
        $error("WIDTH must be a multiple of LANES");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    assign w_wr_en = we & ~clr_busy;
    assign w_rd_en = re & ~clr_busy;
    assign w_col = (RW_MODE == 1) && w_wr_en && (addr_write == addr_read);
    // clear FSM: state register
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_next;
    end
    // clear FSM: next state
    always_comb begin
        w_next = (r_state == S_IDLE) ? (clr_req ? S_CLEAR : S_IDLE) : (w_last ? S_IDLE : S_CLEAR);
    end
    // clear FSM: outputs
    always_comb begin
        clr_busy = (r_state == S_CLEAR);
        clr_done = r_done;
        w_last = clr_busy && (r_cnt == '1);
    end
    // sweep address counter and the done pulse that follows the final clear write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt <= clr_busy ? r_cnt + 1'b1 : '0;
            r_done <= w_last;
        end
    end
    // expand lane mask to bit mask for the write-first merge
    always_comb begin
        w_bits = '0;
        for (int l = 0; l < LANES; l++) w_bits[l*LW +: LW] = {LW{wmask[l]}};
        w_rd_word = w_col ? ((r_mem[addr_read] & ~w_bits) | (data_in & w_bits)) : r_mem[addr_read];
    end
    // array writes: the sweep owns the array while busy, stopping on reset so a partial clear is kept
    always_ff @(posedge clk) begin
        if (clr_busy && !rst) r_mem[r_cnt] <= CLR_VAL;
        else if (w_wr_en) begin
            for (int l = 0; l < LANES; l++)
                if (wmask[l]) r_mem[addr_write][l*LW +: LW] <= data_in[l*LW +: LW];
        end
    end
    // first read stage; data holds when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rd_en;
            if (w_rd_en) r_d1 <= w_rd_word;
        end
    end
    // optional output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) r_d2 <= r_d1;
        end
    end
    assign data_out = (READ_LATENCY == 2) ? r_d2 : r_d1;
    assign data_valid = (READ_LATENCY == 2) ? r_v2 : r_v1;
endmodule

// File: tb/tb_bram_sdp_mlx.sv
// tb_bram_sdp_mlx: directed checks of three shared-stimulus RAM configurations
module tb_bram_sdp_mlx;
    logic clk = 0, rst = 1, we = 0, re = 0, clr_req = 0;
    logic [2:0] wmask = '0;
    logic [7:0] addr_write = '0, addr_read = '0;
    logic [11:0] data_in = '0;
    logic [11:0] dout [3];
    logic dv [3], busy [3], done [3];
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    bram_sdp_mlx #(.READ_LATENCY(1), .RW_MODE(0), .CLR_VAL(12'h0F0)) u_rf (
        .clk(clk), .rst(rst), .we(we), .wmask(wmask), .addr_write(addr_write), .data_in(data_in),
        .re(re), .addr_read(addr_read), .data_out(dout[0]), .data_valid(dv[0]),
        .clr_req(clr_req), .clr_busy(busy[0]), .clr_done(done[0]));
    bram_sdp_mlx #(.READ_LATENCY(1), .RW_MODE(1), .CLR_VAL(12'h0F0)) u_wf (
        .clk(clk), .rst(rst), .we(we), .wmask(wmask), .addr_write(addr_write), .data_in(data_in),
        .re(re), .addr_read(addr_read), .data_out(dout[1]), .data_valid(dv[1]),
        .clr_req(clr_req), .clr_busy(busy[1]), .clr_done(done[1]));
    bram_sdp_mlx #(.READ_LATENCY(2), .RW_MODE(0), .CLR_VAL(12'h0F0)) u_l2 (
        .clk(clk), .rst(rst), .we(we), .wmask(wmask), .addr_write(addr_write), .data_in(data_in),
        .re(re), .addr_read(addr_read), .data_out(dout[2]), .data_valid(dv[2]),
        .clr_req(clr_req), .clr_busy(busy[2]), .clr_done(done[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [11:0] d, input logic [2:0] m);
        we = 1; addr_write = a; data_in = d; wmask = m;
        step();
        we = 0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [11:0] exp);
        re = 1; addr_read = a;
        step();
        re = 0;
        checks++;
        if (dout[0] !== exp || dv[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s lat1 addr=%h got=%h/%b want=%h/1", name, a, dout[0], dv[0], exp);
        end
        step();
        checks++;
        if (dout[2] !== exp || dv[2] !== 1'b1 || dv[0] !== 1'b0) begin
            failures++;
            $display("FAIL %s lat2 addr=%h got=%h/%b lat1_valid=%b want=%h/1/0", name, a, dout[2], dv[2], dv[0], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i] !== 12'h000 || dv[i] !== 1'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut=%0d got dout=%h dv=%b busy=%b done=%b want 000/0/0/0", i, dout[i], dv[i], busy[i], done[i]);
            end
        end
        rst = 0;
    endtask

    task automatic test_write_read();
        write(8'h00, 12'h123, 3'b111);
        read_chk("basic", 8'h00, 12'h123);
        step();
        checks++;
        if (dv[0] !== 1'b0 || dv[2] !== 1'b0 || dout[0] !== 12'h123 || dout[2] !== 12'h123) begin
            failures++;
            $display("FAIL hold got dv=%b/%b dout=%h/%h want 0/0 123/123", dv[0], dv[2], dout[0], dout[2]);
        end
    endtask

    task automatic test_lane_mask();
        write(8'h05, 12'h456, 3'b111);
        write(8'h05, 12'hABC, 3'b010);
        write(8'h06, 12'h789, 3'b111);
        read_chk("lane_mask", 8'h05, 12'h4B6);
        write(8'h00, 12'hFFF, 3'b000);
        read_chk("mask_zero", 8'h00, 12'h123);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [3] = '{8'h00, 8'h05, 8'h06};
        logic [11:0] e [3] = '{12'h123, 12'h4B6, 12'h789};
        for (int i = 0; i < 5; i++) begin
            re = (i < 3);
            addr_read = a[i < 3 ? i : 2];
            step();
            checks++;
            if (dv[0] !== (i < 3) || (i < 3 && dout[0] !== e[i])) begin
                failures++;
                $display("FAIL b2b lat1 cyc=%0d got=%h/%b", i, dout[0], dv[0]);
            end
            checks++;
            if (dv[2] !== (i >= 1 && i <= 3) || (i >= 1 && i <= 3 && dout[2] !== e[i-1])) begin
                failures++;
                $display("FAIL b2b lat2 cyc=%0d got=%h/%b", i, dout[2], dv[2]);
            end
        end
        re = 0;
    endtask

    task automatic test_collision();
        write(8'h07, 12'h111, 3'b111);
        we = 1; addr_write = 8'h06; data_in = 12'hFFF; wmask = 3'b111; re = 1; addr_read = 8'h06;
        step();
        we = 0; re = 0;
        checks++;
        if (dout[0] !== 12'h789) begin
            failures++;
            $display("FAIL coll_read_first got=%h want=789", dout[0]);
        end
        checks++;
        if (dout[1] !== 12'hFFF) begin
            failures++;
            $display("FAIL coll_write_first got=%h want=FFF", dout[1]);
        end
        step();
        checks++;
        if (dout[2] !== 12'h789 || dv[2] !== 1'b1) begin
            failures++;
            $display("FAIL coll_lat2 got=%h/%b want=789/1", dout[2], dv[2]);
        end
        we = 1; addr_write = 8'h07; data_in = 12'h2A3; wmask = 3'b101; re = 1; addr_read = 8'h07;
        step();
        we = 0; re = 0;
        checks++;
        if (dout[0] !== 12'h111 || dout[1] !== 12'h213) begin
            failures++;
            $display("FAIL coll_partial got rf=%h wf=%h want 111/213", dout[0], dout[1]);
        end
        read_chk("after_coll", 8'h07, 12'h213);
    endtask

    task automatic test_reset_mid_read();
        re = 1; addr_read = 8'h00;
        step();
        re = 0; rst = 1;
        step();
        rst = 0;
        checks++;
        if (dv[0] !== 1'b0 || dv[2] !== 1'b0 || dout[2] !== 12'h000) begin
            failures++;
            $display("FAIL rst_mid_read got dv=%b/%b dout2=%h want 0/0/000", dv[0], dv[2], dout[2]);
        end
    endtask

    task automatic test_clear();
        int n = 0, bad_v = 0, bad_d = 0;
        clr_req = 1;
        step();
        clr_req = 0;
        while (busy[0] === 1'b1 && n < 400) begin
            n++;
            if (dv[0] !== 1'b0 || dv[2] !== 1'b0) bad_v++;
            if (done[0] !== 1'b0) bad_d++;
            we = (n == 5); addr_write = 8'h10; data_in = 12'h555; wmask = 3'b111;
            re = (n >= 2); addr_read = 8'h10;
            step();
        end
        we = 0; re = 0;
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL clr_busy_len got=%0d want=256", n);
        end
        checks++;
        if (bad_v != 0 || bad_d != 0) begin
            failures++;
            $display("FAIL clr_quiet got valids=%0d dones=%0d want 0/0", bad_v, bad_d);
        end
        checks++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0 || dv[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_done_pulse got done=%b busy=%b dv=%b want 1/0/0", done[0], busy[0], dv[0]);
        end
        step();
        checks++;
        if (done[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_done_width got=%b want=0", done[0]);
        end
        for (int a = 0; a < 256; a++) begin
            re = 1; addr_read = 8'(a);
            step();
            checks++;
            if (dout[0] !== 12'h0F0 || dv[0] !== 1'b1) begin
                failures++;
                $display("FAIL clr_val addr=%h got=%h/%b want=0F0/1", a, dout[0], dv[0]);
            end
        end
        re = 0;
        step();
    endtask

    task automatic test_reset_mid_clear();
        logic [11:0] exp;
        for (int a = 8'h60; a < 8'h70; a++) write(8'(a), 12'(12'h300 + a), 3'b111);
        clr_req = 1;
        step();
        clr_req = 0;
        for (int i = 0; i < 100; i++) step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (busy[0] !== 1'b0 || dv[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_clear got busy=%b dv=%b done=%b want 0/0/0", busy[0], dv[0], done[0]);
        end
        step();
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_clear_after got done=%b busy=%b want 0/0", done[0], busy[0]);
        end
        for (int a = 8'h60; a < 8'h70; a++) begin
            exp = (a < 8'h64) ? 12'h0F0 : 12'(12'h300 + a);
            read_chk("partial_clear", 8'(a), exp);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_lane_mask();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
